// File: rtl/debounce_pkg.sv
// Shared types for the debounced button bank.
// Long-press support is enabled with DEBOUNCE_BANK_LONG_PRESS_EN.
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LO = 2'd0,
    B_HI = 2'd1,
    S_HI = 2'd2,
    B_LO = 2'd3
  } chan_state_e;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2,
    LONG    = 2'd3
  } evt_kind_e;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One button channel: synchroniser, debounce FSM, window counter.
// DEBOUNCE_BANK_LONG_PRESS_EN adds the long-press counter.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int CNT_W  = 21,
  parameter int LONG_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_rel
`ifdef DEBOUNCE_BANK_LONG_PRESS_EN
  ,
  output logic o_long
`endif
);

  localparam logic [CNT_W-1:0] WIN_MAX =
    CNT_W'((1 << (CNT_W - 1)) - 1);

  logic [1:0]       r_sync;
  chan_state_e      r_st;
  chan_state_e      w_st_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_in;
  logic             w_done;

  assign w_in   = r_sync[1];
  assign w_done = (r_cnt == WIN_MAX);

  always_comb begin
    w_st_nx  = r_st;
    w_cnt_nx = r_cnt;
    unique case (r_st)
      S_LO: begin
        if (w_in) begin
          w_st_nx  = B_HI;
          w_cnt_nx = '0;
        end
      end
      B_HI: begin
        if (!w_in) begin
          w_st_nx = S_LO;
        end else if (w_done) begin
          w_st_nx  = S_HI;
          w_cnt_nx = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      // keeps counting whole windows for the long-press prescaler
      S_HI: begin
        if (!w_in) begin
          w_st_nx  = B_LO;
          w_cnt_nx = '0;
        end else if (w_done) begin
          w_cnt_nx = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      B_LO: begin
        if (w_in) begin
          w_st_nx  = S_HI;
          w_cnt_nx = '0;
        end else if (w_done) begin
          w_st_nx  = S_LO;
          w_cnt_nx = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: begin
        w_st_nx  = S_LO;
        w_cnt_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
      r_st   <= S_LO;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      r_st   <= w_st_nx;
      r_cnt  <= w_cnt_nx;
    end
  end

  assign o_level = (r_st == S_HI) || (r_st == B_LO);
  assign o_press = (r_st == B_HI) && w_in && w_done;
  assign o_rel   = (r_st == B_LO) && !w_in && w_done;

`ifdef DEBOUNCE_BANK_LONG_PRESS_EN
  localparam logic [LONG_W-1:0] L_PRE =
    {LONG_W{1'b1}} - 1'b1;

  logic [LONG_W-1:0] r_long;
  logic              w_in_hi;

  assign w_in_hi = (r_st == S_HI) && w_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_long <= '0;
    end else if (!w_in_hi) begin
      r_long <= '0;
    end else if (w_done && !(&r_long)) begin
      r_long <= r_long + 1'b1;
    end
  end

  assign o_long = w_in_hi && w_done && (r_long == L_PRE);
`endif

endmodule

// File: rtl/debounce_bank.sv
// Bank of debounced buttons with a single valid/ready event queue.
// DEBOUNCE_BANK_LONG_PRESS_EN enables LONG events.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH   = 8,
  parameter int CNT_W  = 21,
  parameter int LONG_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         btn,
  output logic [N_CH-1:0]         level,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [ch_w(N_CH)-1:0]   evt_ch,
  output logic [1:0]              evt_kind,
  output logic                    evt_ovf
);

  localparam int CW = ch_w(N_CH);

  logic [N_CH-1:0] w_req_p;
  logic [N_CH-1:0] w_req_r;
  logic [N_CH-1:0] w_req_l;
  logic [N_CH-1:0] r_pend_p;
  logic [N_CH-1:0] r_pend_r;
  logic [N_CH-1:0] w_acc_p;
  logic [N_CH-1:0] w_acc_r;
  logic [N_CH-1:0] w_acc_l;
  logic [N_CH-1:0] w_keep_p;
  logic [N_CH-1:0] w_keep_r;
  logic [N_CH-1:0] w_keep_l;
  logic            w_acc;
  logic            r_valid;
  logic [CW-1:0]   r_ch;
  evt_kind_e       r_kind;
  logic            r_ovf;
  logic            w_sel_v;
  logic [CW-1:0]   w_sel_ch;
  evt_kind_e       w_sel_k;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    debounce_chan #(
      .CNT_W  (CNT_W),
      .LONG_W (LONG_W)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (btn[gi]),
      .o_level (level[gi]),
      .o_press (w_req_p[gi]),
      .o_rel   (w_req_r[gi])
`ifdef DEBOUNCE_BANK_LONG_PRESS_EN
      ,
      .o_long  (w_req_l[gi])
`endif
    );
  end

  assign w_acc = r_valid && evt_ready;

  assign w_acc_p = (w_acc && r_kind == PRESS) ?
                   (N_CH'(1) << r_ch) : '0;
  assign w_acc_r = (w_acc && r_kind == RELEASE) ?
                   (N_CH'(1) << r_ch) : '0;
  assign w_acc_l = (w_acc && r_kind == LONG) ?
                   (N_CH'(1) << r_ch) : '0;

  assign w_keep_p = r_pend_p & ~w_acc_p;
  assign w_keep_r = r_pend_r & ~w_acc_r;

`ifdef DEBOUNCE_BANK_LONG_PRESS_EN
  logic [N_CH-1:0] r_pend_l;

  assign w_keep_l = r_pend_l & ~w_acc_l;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_l <= '0;
    end else begin
      r_pend_l <= w_keep_l | w_req_l;
    end
  end
`else
  assign w_req_l  = '0;
  assign w_keep_l = '0 & w_acc_l & w_req_l;
`endif

  // candidates exclude the bit being accepted so a new event
  // can be loaded in the same cycle as the handshake
  always_comb begin
    w_sel_v  = 1'b0;
    w_sel_ch = '0;
    w_sel_k  = NONE;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_keep_p[i] || w_keep_l[i] || w_keep_r[i]) begin
        w_sel_v  = 1'b1;
        w_sel_ch = CW'(i);
        w_sel_k  = w_keep_p[i] ? PRESS :
                   (w_keep_l[i] ? LONG : RELEASE);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_p <= '0;
      r_pend_r <= '0;
      r_valid  <= 1'b0;
      r_ch     <= '0;
      r_kind   <= NONE;
      r_ovf    <= 1'b0;
    end else begin
      r_pend_p <= w_keep_p | w_req_p;
      r_pend_r <= w_keep_r | w_req_r;
      r_ovf    <= |((w_req_p & w_keep_p) |
                    (w_req_r & w_keep_r) |
                    (w_req_l & w_keep_l));
      if (!r_valid || evt_ready) begin
        r_valid <= w_sel_v;
        r_ch    <= w_sel_ch;
        r_kind  <= w_sel_k;
      end
    end
  end

  assign evt_valid = r_valid;
  assign evt_ch    = r_ch;
  assign evt_kind  = r_kind;
  assign evt_ovf   = r_ovf;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank (N_CH=4, W=8, LONG_W=2).
// Expects LONG events only when DEBOUNCE_BANK_LONG_PRESS_EN is set.
module tb_debounce_bank;

  localparam int N_CH   = 4;
  localparam int CNT_W  = 4;
  localparam int LONG_W = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn = '0;
  logic       evt_ready = 1'b0;
  logic [3:0] level;
  logic       evt_valid;
  logic [1:0] evt_ch;
  logic [1:0] evt_kind;
  logic       evt_ovf;

  debounce_bank #(
    .N_CH   (N_CH),
    .CNT_W  (CNT_W),
    .LONG_W (LONG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .level     (level),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_kind  (evt_kind),
    .evt_ovf   (evt_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ovf_cnt = 0;
  logic [3:0] log_q[$];

  always @(posedge clk) begin
    if (rst && evt_valid && evt_ready)
      log_q.push_back({evt_ch, evt_kind});
    if (evt_ovf)
      ovf_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_log(input string tag, input int idx,
                         input logic [3:0] exp);
    if (log_q.size() > idx)
      chk(tag, log_q[idx], exp);
    else
      chk({tag, "_size"}, log_q.size(), idx + 1);
  endtask

  initial begin
    int b;
    int o;
    logic bad;

    cyc(2);
    chk("rst_level", level, 4'h0);
    chk("rst_valid", evt_valid, 1'b0);
    chk("rst_ch", evt_ch, 2'd0);
    chk("rst_kind", evt_kind, 2'd0);
    chk("rst_ovf", evt_ovf, 1'b0);
    rst = 1'b1;
    cyc(2);

    // clean rise on channel 2
    evt_ready = 1'b1;
    b = log_q.size();
    btn[2] = 1'b1;
    cyc(10);
    chk("t1_lvl_e10", level[2], 1'b0);
    cyc(1);
    chk("t1_lvl_e11", level[2], 1'b1);
    cyc(1);
    chk("t1_valid", evt_valid, 1'b1);
    chk("t1_evt", {evt_ch, evt_kind}, 4'b10_01);
    cyc(1);
    chk("t1_idle", evt_valid, 1'b0);
    chk("t1_cnt", log_q.size(), b + 1);
    btn[2] = 1'b0;
    cyc(16);
    chk("t1_lvl_rel", level[2], 1'b0);
    chk_log("t1_rel", b + 1, 4'b10_10);

    // bouncing channel 1
    b = log_q.size();
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) btn[1] = ~btn[1];
      cyc(1);
      if (level[1]) bad = 1'b1;
    end
    chk("t2_no_lvl", bad, 1'b0);
    chk("t2_no_evt", log_q.size(), b);
    btn[1] = 1'b1;
    cyc(14);
    chk("t2_lvl", level[1], 1'b1);
    chk("t2_cnt", log_q.size(), b + 1);
    chk_log("t2_press", b, 4'b01_01);
    btn[1] = 1'b0;
    cyc(16);

    // simultaneous presses with back-pressure
    evt_ready = 1'b0;
    b = log_q.size();
    btn[0] = 1'b1;
    btn[3] = 1'b1;
    cyc(12);
    chk("t3_valid", evt_valid, 1'b1);
    chk("t3_evt0", {evt_ch, evt_kind}, 4'b00_01);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      if (!evt_valid || {evt_ch, evt_kind} != 4'b00_01)
        bad = 1'b1;
    end
    chk("t3_stable", bad, 1'b0);
    evt_ready = 1'b1;
    cyc(1);
    chk("t3_next_v", evt_valid, 1'b1);
    chk("t3_evt3", {evt_ch, evt_kind}, 4'b11_01);
    cyc(1);
    chk("t3_idle", evt_valid, 1'b0);
    chk_log("t3_l0", b, 4'b00_01);
    chk_log("t3_l1", b + 1, 4'b11_01);
    btn[0] = 1'b0;
    btn[3] = 1'b0;
    cyc(16);
    chk_log("t3_rel0", b + 2, 4'b00_10);
    chk_log("t3_rel3", b + 3, 4'b11_10);

    // overflow on repeated press while stalled
    evt_ready = 1'b0;
    b = log_q.size();
    o = ovf_cnt;
    btn[0] = 1'b1;
    cyc(14);
    btn[0] = 1'b0;
    cyc(14);
    btn[0] = 1'b1;
    cyc(14);
    chk("t4_ovf", ovf_cnt - o, 1);
    chk("t4_evt", {evt_valid, evt_ch, evt_kind}, 5'b1_00_01);
    evt_ready = 1'b1;
    cyc(4);
    chk("t4_cnt", log_q.size(), b + 2);
    chk_log("t4_l0", b, 4'b00_01);
    chk_log("t4_l1", b + 1, 4'b00_10);
    btn[0] = 1'b0;
    cyc(16);
    chk_log("t4_l2", b + 2, 4'b00_10);
    chk("t4_ovf_end", ovf_cnt - o, 1);

    // long hold on channel 0
    b = log_q.size();
    btn[0] = 1'b1;
    cyc(40);
    btn[0] = 1'b0;
    cyc(16);
    chk_log("t5_press", b, 4'b00_01);
`ifdef DEBOUNCE_BANK_LONG_PRESS_EN
    chk("t5_cnt", log_q.size(), b + 3);
    chk_log("t5_long", b + 1, 4'b00_11);
    chk_log("t5_rel", b + 2, 4'b00_10);
`else
    chk("t5_cnt", log_q.size(), b + 2);
    chk_log("t5_rel", b + 1, 4'b00_10);
`endif

    // async reset with a press pending
    evt_ready = 1'b0;
    btn[1] = 1'b1;
    cyc(14);
    chk("t6_pre_lvl", level[1], 1'b1);
    chk("t6_pre_v", evt_valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("t6_lvl", level, 4'h0);
    chk("t6_valid", evt_valid, 1'b0);
    chk("t6_ch", evt_ch, 2'd0);
    chk("t6_kind", evt_kind, 2'd0);
    chk("t6_ovf", evt_ovf, 1'b0);
    cyc(2);
    rst = 1'b1;
    evt_ready = 1'b1;
    b = log_q.size();
    cyc(11);
    chk("t6_quiet_v", evt_valid, 1'b0);
    chk("t6_quiet_n", log_q.size(), b);
    cyc(3);
    chk("t6_lvl_back", level[1], 1'b1);
    chk("t6_cnt", log_q.size(), b + 1);
    chk_log("t6_press", b, 4'b01_01);
    btn[1] = 1'b0;
    cyc(16);
    chk_log("t6_rel", b + 1, 4'b01_10);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 SHALL have parameter N_CH, default 8: number of independent button channels, range 1..32.
REQ-002 SHALL have parameter CNT_W, default 21: debounce counter width; stable window W = 2**(CNT_W-1) cycles (10 ms at 100 MHz), range 2..24.
REQ-003 SHALL have parameter LONG_W, default 8: long-press prescale width, counted in debounce windows.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port btn, input, N_CH bits: raw asynchronous button inputs.
REQ-007 SHALL have port level, output, N_CH bits: debounced state per channel.
REQ-008 SHALL have port evt_valid, output, 1 bit: event available.
REQ-009 SHALL have port evt_ready, input, 1 bit: consumer accepts the event.
REQ-010 SHALL have port evt_ch, output, $clog2(N_CH) bits (minimum 1): channel of the event.
REQ-011 SHALL have port evt_kind, output, 2 bits: event type; 1 = PRESS, 2 = RELEASE, 3 = LONG.
REQ-012 SHALL have port evt_ovf, output, 1 bit: one-cycle pulse when an event is lost.

Function
REQ-013 Each btn bit SHALL pass a 2-flop synchroniser before any use.
REQ-014 Each channel SHALL run FSM S_LO -> B_HI -> S_HI -> B_LO -> S_LO.
- S_LO: synced 1 -> B_HI, counter 0.
- B_HI: synced 0 -> S_LO; counter reaches W-1 -> S_HI.
- S_HI and B_LO: mirror image.
REQ-015 level[i] SHALL be 1 exactly in S_HI and B_LO.
REQ-016 After a clean btn edge, level SHALL change on the (W+3)th rising clk edge counted from the first edge that samples the new value; any bounce restarts the window.
REQ-017 Entering S_HI SHALL raise a PRESS request; entering S_LO from B_LO SHALL raise a RELEASE request; one request per transition.
REQ-018 Per channel and kind, one pending bit SHALL hold the request until accepted.
REQ-019 Arbitration SHALL select the lowest channel index with any pending bit; within a channel, priority is PRESS > LONG > RELEASE.
REQ-020 evt_valid/evt_ch/evt_kind SHALL be registered; once evt_valid is high they SHALL stay stable until the cycle with evt_valid && evt_ready.
REQ-021 On acceptance, the served pending bit SHALL clear, and the next event SHALL be presented on the following cycle (throughput one event per cycle).
REQ-022 A new request for a bit that is pending and not being accepted SHALL be dropped and pulse evt_ovf for one cycle.
REQ-023 A new request for a bit accepted in the same cycle SHALL set that bit again without evt_ovf.

Reset
REQ-024 rst low SHALL immediately drive:
- all FSMs to S_LO, counters and synchronisers to 0;
- level = 0, evt_valid = 0, evt_ch = 0, evt_kind = 0, evt_ovf = 0;
- all pending bits clear.
REQ-025 After rst deasserts mid-press, a held button SHALL produce PRESS after a full window; no RELEASE SHALL be produced for the aborted press.

Configuration
REQ-026 Macro DEBOUNCE_BANK_LONG_PRESS_EN SHALL gate the long-press feature.
- Defined: a per-channel LONG_W-bit counter increments once per completed window while in S_HI.
- At all-ones it raises one LONG request and saturates; leaving S_HI clears it.
- Undefined: no long counter or LONG pending logic is built; evt_kind never equals 3.

Structure
REQ-027 Package debounce_pkg SHALL hold the channel-state enum (S_LO, B_HI, S_HI, B_LO) and the evt_kind enum (PRESS = 1, RELEASE = 2, LONG = 3).
REQ-028 Per-channel synchroniser, FSM, counter and long counter SHALL live in sub-module debounce_chan, instantiated N_CH times.
REQ-029 Pending storage, arbiter and event register SHALL live in debounce_bank.

Verification (N_CH=4, CNT_W=4 so W=8, LONG_W=2)
REQ-030 Clean rise on btn[2], evt_ready=1 -> level[2] rises on edge 11; one PRESS event with ch=2 follows.
REQ-031 btn[1] toggling every 3 cycles for 40 cycles, then held at 1 -> level[1] stays 0 during toggling; exactly one PRESS event after the hold.
REQ-032 Channels 0 and 3 press in the same cycle, evt_ready held 0 for 5 cycles -> PRESS ch=0 held stable; PRESS ch=3 is presented the cycle after acceptance.
REQ-033 Two press/release cycles on channel 0 with evt_ready=0 -> one evt_ovf pulse; queue drains as PRESS ch=0 then RELEASE ch=0.
REQ-034 With macro defined, btn[0] held for 40 cycles -> PRESS, then exactly one LONG after 3 further windows, then RELEASE; with macro undefined -> no LONG event.
REQ-035 rst pulsed low while level[1]=1 and events pending -> all outputs 0 asynchronously; no event is produced until a new press completes.
